// File: rtl/seq_pkg.sv
// Shared types, defaults and helpers for the serial pattern transmitter.
// Defining SEQ_TX_PARITY_EN appends an even-parity bit after the payload.
package seq_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_SYNC_W = 4;
  localparam logic [DEF_SYNC_W-1:0] DEF_SYNC_PATTERN = 4'b1010;

  // Widest payload even_parity() accepts; callers zero-extend, which leaves the XOR unchanged.
  localparam int unsigned PAR_MAX_W = 64;

`ifdef SEQ_TX_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
  typedef enum logic [1:0] {IDLE, SYNC, DATA, PARITY} tx_state_e;
`else
  localparam int unsigned PARITY_BITS = 0;
  typedef enum logic [1:0] {IDLE, SYNC, DATA} tx_state_e;
`endif

  function automatic int unsigned frame_len(input int unsigned sync_w, input int unsigned data_w);
    return sync_w + data_w + PARITY_BITS;
  endfunction

  localparam int unsigned DEF_FRAME_LEN = frame_len(DEF_SYNC_W, DEF_DATA_W);

  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/seq_tx_shifter.sv
// Loadable MSB-first shift register; msb_o is the bit presented on the line at the next advance.
module seq_tx_shifter
  import seq_pkg::*;
#(
  parameter int unsigned W = DEF_FRAME_LEN
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         shift_i,
  output logic         msb_o
);

  logic [W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = load_val_i;
    end else if (shift_i) begin
      sr_d = {sr_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb_o = sr_q[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: sync pattern then payload MSB-first, paced by tx_en.
// SEQ_TX_PARITY_EN adds a trailing even-parity bit and the PARITY state.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int unsigned       DATA_W       = DEF_DATA_W,
  parameter int unsigned       SYNC_W       = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_W'(DEF_SYNC_PATTERN)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              tx_en,
  output logic              dout,
  output logic              dout_valid,
  output logic              frame_start,
  output logic              busy
);

  localparam int unsigned FRAME_L = frame_len(SYNC_W, DATA_W);
  localparam int unsigned CNT_W   = $clog2(FRAME_L);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_L - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_c;
  logic             dout_q, dout_d;
  logic             dv_q, dv_d;
  logic             fs_q, fs_d;
  logic             busy_c, last_c, advance_c, accept_c, next_bit_c;
  logic [FRAME_L-1:0] frame_c;

`ifdef SEQ_TX_PARITY_EN
  assign frame_c = {SYNC_PATTERN, in_data, even_parity(PAR_MAX_W'(in_data))};
`else
  assign frame_c = {SYNC_PATTERN, in_data};
`endif

  assign busy_c    = (state_q != IDLE);
  assign last_c    = busy_c && (cnt_q == LAST_IDX);
  assign advance_c = busy_c && tx_en;
  assign in_ready  = !busy_c || (last_c && tx_en);
  assign accept_c  = in_valid && in_ready;
  assign cnt_inc_c = cnt_q + CNT_W'(1);

  // The first frame bit goes straight to dout, so the shifter holds only the remainder.
  seq_tx_shifter #(
    .W (FRAME_L)
  ) u_shifter (
    .clk        (clk),
    .resetn     (resetn),
    .load_i     (accept_c),
    .load_val_i ({frame_c[FRAME_L-2:0], 1'b0}),
    .shift_i    (advance_c && !last_c),
    .msb_o      (next_bit_c)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    dv_d    = dv_q;
    fs_d    = fs_q;
    if (accept_c) begin
      state_d = SYNC;
      cnt_d   = '0;
      dout_d  = SYNC_PATTERN[SYNC_W-1];
      dv_d    = 1'b1;
      fs_d    = 1'b1;
    end else if (advance_c) begin
      if (last_c) begin
        state_d = IDLE;
        cnt_d   = '0;
        dout_d  = 1'b0;
        dv_d    = 1'b0;
        fs_d    = 1'b0;
      end else begin
        cnt_d  = cnt_inc_c;
        dout_d = next_bit_c;
        fs_d   = 1'b0;
        if (32'(cnt_inc_c) < SYNC_W) begin
          state_d = SYNC;
`ifdef SEQ_TX_PARITY_EN
        end else if (32'(cnt_inc_c) >= SYNC_W + DATA_W) begin
          state_d = PARITY;
`endif
        end else begin
          state_d = DATA;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      dv_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      fs_q    <= fs_d;
    end
  end

  assign dout        = dout_q;
  assign dout_valid  = dv_q;
  assign frame_start = fs_q;
  assign busy        = busy_c;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: table of hand-derived frames plus a scoreboard of expected serial bits.
module tb_seq_pattern_tx;

`ifdef SEQ_TX_PARITY_EN
  localparam int unsigned L = 13;
`else
  localparam int unsigned L = 12;
`endif

  typedef struct {
    logic [7:0]  data;
    int          period;
    logic        poke;
    logic [11:0] exp_bits;
    logic        exp_par;
  } vec_t;

  typedef struct packed {
    logic b;
    logic fs;
    logic last;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       tx_en = 1'b1;
  logic       dout, dout_valid, frame_start, busy;

  seq_pattern_tx dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .tx_en       (tx_en),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .frame_start (frame_start),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int   tx_period = 1;
  int   tx_phase = 0;
  logic tx_rand = 1'b0;

  always @(posedge clk) begin
    #1;
    if (tx_rand) begin
      tx_en = 1'($urandom_range(0, 1));
    end else begin
      tx_en = (tx_phase == 0);
      tx_phase = (tx_phase + 1) % tx_period;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  exp_t q[$];
  int   pass_cnt = 0;
  int   chk_cnt = 0;
  int   valid_cnt = 0;
  int   fs_cnt = 0;
  int   last_fs_cyc = 0;
  int   fs_gap = 0;
  logic prev_fs = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Every cycle: compare the line against the scoreboard head; consume it on tx_en.
  always @(negedge clk) begin
    if (resetn) begin
      if (dout_valid) begin
        valid_cnt++;
        if (frame_start) fs_cnt++;
        if (frame_start && !prev_fs) begin
          fs_gap = cyc - last_fs_cyc;
          last_fs_cyc = cyc;
        end
        if (q.size() == 0) begin
          chk("extra_bit", 32'(dout_valid), 32'(0));
        end else begin
          chk("dout", 32'(dout), 32'(q[0].b));
          chk("frame_start", 32'(frame_start), 32'(q[0].fs));
          chk("in_ready_busy", 32'(in_ready), 32'(q[0].last & tx_en));
          chk("busy", 32'(busy), 32'(1));
          if (tx_en) q.delete(0);
        end
      end else begin
        chk("idle_dout", 32'(dout), 32'(0));
        chk("idle_fs", 32'(frame_start), 32'(0));
        chk("idle_busy", 32'(busy), 32'(0));
        chk("idle_ready", 32'(in_ready), 32'(1));
      end
      prev_fs = dout_valid && frame_start;
    end
  end

  function automatic logic [L-1:0] frame_of(input logic [11:0] bits, input logic par);
    logic [12:0] full;
    full = {bits, par};
    return L'(full >> (13 - L));
  endfunction

  task automatic set_period(input int p);
    tx_rand = 1'b0;
    tx_period = p;
    tx_phase = 0;
  endtask

  task automatic send(input logic [7:0] d, input logic [L-1:0] f);
    int n;
    exp_t e;
    n = 0;
    @(posedge clk);
    #1;
    in_data = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(in_ready), 32'(1));
    for (int i = 0; i < int'(L); i++) begin
      e.b = f[L-1-i];
      e.fs = (i == 0);
      e.last = (i == int'(L) - 1);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || q.size() != 0) && n < 600);
    chk("drain_queue", 32'(q.size()), 32'(0));
    chk("end_busy", 32'(busy), 32'(0));
  endtask

  task automatic poke_midframe();
    repeat (4) @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data = 8'hEE;
    repeat (3) begin
      @(negedge clk);
      chk("ready_midframe", 32'(in_ready), 32'(0));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  vec_t       tbl[7];
  logic [7:0] rd;

  initial begin
    tbl[0] = '{8'hA5, 1, 1'b0, 12'b1010_1010_0101, 1'b0};
    tbl[1] = '{8'h3C, 1, 1'b0, 12'b1010_0011_1100, 1'b0};
    tbl[2] = '{8'h01, 3, 1'b1, 12'b1010_0000_0001, 1'b1};
    tbl[3] = '{8'h07, 2, 1'b0, 12'b1010_0000_0111, 1'b1};
    tbl[4] = '{8'h03, 1, 1'b0, 12'b1010_0000_0011, 1'b0};
    tbl[5] = '{8'h80, 4, 1'b1, 12'b1010_1000_0000, 1'b1};
    tbl[6] = '{8'hFF, 3, 1'b0, 12'b1010_1111_1111, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_dout", 32'(dout), 32'(0));
    chk("reset_dout_valid", 32'(dout_valid), 32'(0));
    chk("reset_frame_start", 32'(frame_start), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_in_ready", 32'(in_ready), 32'(1));
    resetn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      set_period(tbl[i].period);
      valid_cnt = 0;
      fs_cnt = 0;
      send(tbl[i].data, frame_of(tbl[i].exp_bits, tbl[i].exp_par));
      if (tbl[i].poke) poke_midframe();
      wait_idle();
      chk("valid_cycles_lo", 32'(valid_cnt >= (int'(L) - 1) * tbl[i].period + 1), 32'(1));
      chk("valid_cycles_hi", 32'(valid_cnt <= int'(L) * tbl[i].period), 32'(1));
      chk("fs_cycles_lo", 32'(fs_cnt >= 1), 32'(1));
      chk("fs_cycles_hi", 32'(fs_cnt <= tbl[i].period), 32'(1));
    end

    // Back-to-back frames with no idle gap between them.
    set_period(1);
    valid_cnt = 0;
    fs_cnt = 0;
    send(8'h3C, frame_of(12'b1010_0011_1100, 1'b0));
    send(8'hFF, frame_of(12'b1010_1111_1111, 1'b0));
    wait_idle();
    chk("b2b_valid_cycles", 32'(valid_cnt), 32'(2 * L));
    chk("b2b_fs_cycles", 32'(fs_cnt), 32'(2));
    chk("b2b_fs_spacing", 32'(fs_gap), 32'(L));

    // Asynchronous reset in the middle of a frame.
    send(8'hA5, frame_of(12'b1010_1010_0101, 1'b0));
    repeat (4) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst_dout", 32'(dout), 32'(0));
    chk("midrst_dout_valid", 32'(dout_valid), 32'(0));
    chk("midrst_frame_start", 32'(frame_start), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    q.delete();
    @(posedge clk);
    #3;
    resetn = 1'b1;
    @(negedge clk);
    chk("postrst_in_ready", 32'(in_ready), 32'(1));
    chk("postrst_dout", 32'(dout), 32'(0));

    // Random words under a random tx_en strobe.
    tx_rand = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rd = 8'($urandom);
      send(rd, frame_of({4'b1010, rd}, ^rd));
    end
    wait_idle();
    set_period(1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, chk_cnt);
    $fatal(1);
  end

endmodule
